// File: rtl/inst_pkg.sv
// rtl/inst_pkg.sv - shared widths, fetch-state encoding and buffer entry type
package inst_pkg;

    localparam int ADDR_W     = 16;
    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STALL  = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - small synchronous FIFO of fetched {pc, instr} entries
module fetch_buf
    import inst_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    assign do_pop = pop && (count_q != '0);

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - PC/credit/redirect control for instruction fetch; INST_FETCH_HALT_EN adds halt-opcode stop
module inst_fetch_ctrl
    import inst_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
    parameter int                BUF_DEPTH   = 2,
    parameter logic [5:0]        HALT_OPCODE = 6'b111111
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               redir_valid,
    input  logic [ADDR_W-1:0]  redir_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted
);

    localparam int             CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(BUF_DEPTH);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  buf_count;
    logic [CNT_W:0]    occupancy;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              pop;
    logic              capture;
    logic              credit;
    logic              halt_hit;

    assign out_valid  = (buf_count != '0);
    assign out_instr  = head.instr;
    assign out_pc     = head.pc;
    assign pop        = out_valid & out_ready;
    assign capture    = inflight_q & ~redir_valid;
    assign push_entry = '{pc: infl_pc_q, instr: mem_rdata};

    // A pop this cycle frees a slot in time for the word requested now, which keeps one fetch per cycle.
    assign occupancy = {1'b0, buf_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    assign credit    = (occupancy < DEPTH_L);
    assign mem_req   = rst_n & run & credit & ~redir_valid & (state_q != HALTED);
    assign mem_addr  = pc_q;

`ifdef INST_FETCH_HALT_EN
    assign halt_hit = capture && (mem_rdata[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
    assign halted   = (state_q == HALTED);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    always_comb begin
        pc_d       = pc_q;
        infl_pc_d  = infl_pc_q;
        inflight_d = 1'b0;
        if (redir_valid) begin
            pc_d = redir_pc;
        end else if (mem_req) begin
            pc_d       = pc_q + 1'b1;
            infl_pc_d  = pc_q;
            // A request racing the halt word's capture is dropped rather than buffered.
            inflight_d = ~halt_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            infl_pc_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            infl_pc_q  <= infl_pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (redir_valid) begin
            state_q <= run ? RUN : IDLE;
        end else if (halt_hit) begin
            state_q <= HALTED;
        end else if (state_q != HALTED) begin
            if (!run) begin
                state_q <= IDLE;
            end else if (credit) begin
                state_q <= RUN;
            end else begin
                state_q <= STALL;
            end
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redir_valid),
        .head      (head),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - self-checking bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

    localparam int BUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        redir_valid;
    logic [15:0] redir_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] out_pc;
    logic        halted;

    int errors = 0;
    int checks = 0;

    inst_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [15:0] a);
`ifdef INST_FETCH_HALT_EN
        if (a == 16'd3) return 32'hFC00_0000;
`endif
        return 32'(a) + 32'd100;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, want, $time);
        end
    endtask

    always @(posedge clk) begin
        if (mem_req) mem_rdata <= word(mem_addr);
    end

    typedef struct {
        logic [15:0] pc;
        int          rdy;
    } ent_t;

    ent_t        q[$];
    logic [15:0] got[$];
    logic [15:0] fpc;
    bit          halted_m;
    int          cyc = 0;
    bit          ev, mpop, er, hit;
    logic [31:0] w;

    // Model: every request becomes visible two cycles later, in order, until a redirect/reset/halt discards it.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            fpc      = 16'h0000;
            halted_m = 1'b0;
        end else begin
            if (out_valid && out_ready) got.push_back(out_pc);
            ev = (q.size() > 0) && (q[0].rdy <= cyc);
            chk("m_out_valid", out_valid, ev);
            if (ev) begin
                chk("m_out_pc", out_pc, q[0].pc);
                chk("m_out_instr", out_instr, word(q[0].pc));
            end
            mpop = ev && out_ready;
            er = run && !redir_valid && !halted_m && ((q.size() - int'(mpop)) < BUF_DEPTH);
            chk("m_mem_req", mem_req, er);
            if (er) chk("m_mem_addr", mem_addr, fpc);
            chk("m_halted", halted, halted_m);
            if (mpop) void'(q.pop_front());
            if (redir_valid) begin
                q.delete();
                fpc      = redir_pc;
                halted_m = 1'b0;
            end else begin
                hit = 1'b0;
`ifdef INST_FETCH_HALT_EN
                for (int i = 0; i < q.size(); i++) begin
                    w = word(q[i].pc);
                    if (q[i].rdy == cyc + 1 && w[31:26] == 6'h3F) begin
                        hit = 1'b1;
                        halted_m = 1'b1;
                        while (q.size() > i + 1) void'(q.pop_back());
                        break;
                    end
                end
`endif
                if (er && !hit) q.push_back('{fpc, cyc + 2});
                if (er) fpc = fpc + 16'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; out_ready = 1'b0;
        redir_valid = 1'b0; redir_pc = '0;
        repeat (2) @(posedge clk);
        samp();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_halted", halted, 0);

        // Streaming with decode always ready
        tick(); rst_n = 1'b1; run = 1'b1; out_ready = 1'b1;
        samp(); chk("t1_req0", mem_req, 1); chk("t1_addr0", mem_addr, 16'd0);
        samp(); chk("t1_lat_valid", out_valid, 0); chk("t1_addr1", mem_addr, 16'd1);
        samp(); chk("t1_first_valid", out_valid, 1); chk("t1_first_pc", out_pc, 16'd0);
        chk("t1_first_instr", out_instr, 32'd100);
        samp(); chk("t1_pc1", out_pc, 16'd1);
        samp(); chk("t1_pc2", out_pc, 16'd2); chk("t1_instr2", out_instr, 32'd102);

        // Asynchronous reset mid-stream
        @(posedge clk); #2;
        chk("t5_pre_valid", out_valid, 1);
        #1 rst_n = 1'b0; out_ready = 1'b0;
        #1;
        chk("t5_mem_req", mem_req, 0);
        chk("t5_mem_addr", mem_addr, 16'h0000);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_out_pc", out_pc, 0);
        chk("t5_out_instr", out_instr, 0);

        // Restart with backpressure for 6 cycles
        tick(); rst_n = 1'b1;
        samp(); chk("t2_req0", mem_req, 1); chk("t2_addr0", mem_addr, 16'd0);
        samp(); chk("t2_req1", mem_req, 1); chk("t2_addr1", mem_addr, 16'd1);
        samp(); chk("t2_nocredit", mem_req, 0);
        samp(); chk("t2_full_req", mem_req, 0); chk("t2_head", out_pc, 16'd0);
        samp(); samp(); chk("t2_hold_pc", out_pc, 16'd0); chk("t2_hold_instr", out_instr, 32'd100);
        tick(); out_ready = 1'b1;
        samp(); chk("t2_rel_pc0", out_pc, 16'd0); chk("t2_rel_addr", mem_addr, 16'd2);
        samp(); chk("t2_rel_pc1", out_pc, 16'd1);
        samp(); chk("t2_rel_pc2", out_pc, 16'd2);

        // Redirect with buffered and in-flight words
        tick(); out_ready = 1'b0; redir_valid = 1'b1; redir_pc = 16'h0040;
        samp(); chk("t3_pre_valid", out_valid, 1); chk("t3_req_low", mem_req, 0);
        tick(); redir_valid = 1'b0; out_ready = 1'b1;
        samp(); chk("t3_flushed", out_valid, 0); chk("t3_addr", mem_addr, 16'h0040);
        samp(); chk("t3_gap", out_valid, 0);
        samp(); chk("t3_pc", out_pc, 16'h0040); chk("t3_instr", out_instr, 32'h0000_00A4);

        // Wrap of the program counter
        tick(); redir_valid = 1'b1; redir_pc = 16'hFFFE;
        tick(); redir_valid = 1'b0;
        samp(); samp();
        samp(); chk("t4_pc_fffe", out_pc, 16'hFFFE);
        samp(); chk("t4_pc_ffff", out_pc, 16'hFFFF);
        samp(); chk("t4_pc_0000", out_pc, 16'h0000); chk("t4_instr_0000", out_instr, 32'd100);
        samp(); chk("t4_pc_0001", out_pc, 16'h0001);

        // Run deassert drains the buffer without new requests
        tick(); run = 1'b0;
        repeat (4) samp();
        chk("t6_no_req", mem_req, 0); chk("t6_drained", out_valid, 0);
        tick(); run = 1'b1;
        repeat (3) samp();

`ifdef INST_FETCH_HALT_EN
        tick(); redir_valid = 1'b1; redir_pc = 16'h0000;
        tick(); redir_valid = 1'b0; got.delete();
        repeat (8) samp();
        chk("h_halted", halted, 1); chk("h_no_req", mem_req, 0);
        chk("h_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("h_seq", got[i], 16'(i));
        tick(); redir_valid = 1'b1; redir_pc = 16'h0010;
        tick(); redir_valid = 1'b0;
        samp(); chk("h_cleared", halted, 0); chk("h_resume", mem_req, 1);
        chk("h_addr", mem_addr, 16'h0010);
        repeat (4) samp();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
